morse_key_scheduler: RTL and testbench

Transmit-side sequencer for the Morse communicator. It accepts 8-bit Morse codes in the same 2-bit-per-symbol packing the capture path produces, and buffers them in a small FIFO. It then plays each code out on a single key line (LED/buzzer driver) with standard unit timing: dot 1, dash 3, intra-character gap 1, character gap 3, word gap 7. It sits between the character source (decoder/host) and the output driver and is the only block that sequences key_out.

---
 rtl/morse_key_scheduler_if.sv | 9 +
 rtl/morse_key_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_morse_key_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/morse_key_scheduler_if.sv
// Code handshake between a character source (master) and morse_key_scheduler (slave).
interface morse_key_scheduler_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;

    modport master (output code_in, output code_valid, input code_ready);
    modport slave  (input code_in, input code_valid, output code_ready);
endinterface

// File: rtl/morse_key_scheduler.sv
// Buffers 2-bit-per-symbol Morse codes and plays them on key_out with unit timing.
// Optional MORSE_SIDETONE_EN adds tone_out, a square wave gated by the mark.
module morse_key_scheduler #(
    parameter int unsigned UNIT_TIME  = 2000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TONE_DIV   = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    morse_key_scheduler_if.slave          code_if,
    output logic                          key_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef MORSE_SIDETONE_EN
    ,
    output logic                          tone_out
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned UW = $clog2(4 * UNIT_TIME);
    localparam logic [UW-1:0] T_1U = UW'(UNIT_TIME - 1);
    localparam logic [UW-1:0] T_3U = UW'(3 * UNIT_TIME - 1);
    localparam logic [UW-1:0] T_4U = UW'(4 * UNIT_TIME - 1);

    if (UNIT_TIME < 2 || FIFO_DEPTH < 2 || TONE_DIV < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("morse_key_scheduler: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SEEK, S_MARK, S_SYM_GAP, S_CHAR_GAP, S_WORD_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [UW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic [2:0]      pairs_q, pairs_d;
    logic            dash_q, dash_d;
    logic            key_out_q, key_out_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      sh_shift;
    logic            push;
    logic            pop;

    function automatic logic is_sym(input logic [1:0] p);
        return (p == 2'b01) || (p == 2'b10);
    endfunction

    function automatic logic any_sym(input logic [7:0] v);
        return is_sym(v[7:6]) || is_sym(v[5:4]) || is_sym(v[3:2]) || is_sym(v[1:0]);
    endfunction

    assign sh_shift = {sh_q[5:0], 2'b00};
    assign push     = code_if.code_valid && ready_q;

    // Symbol sequencer; the unit counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + UW'(1);
        sh_d    = sh_q;
        pairs_d = pairs_q;
        dash_d  = dash_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    pairs_d = 3'd4;
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                if (is_sym(sh_q[7:6])) begin
                    dash_d  = (sh_q[7:6] == 2'b10);
                    state_d = S_MARK;
                end else if (pairs_q == 3'd0 || !any_sym(sh_q)) begin
                    state_d = S_WORD_GAP;
                end else begin
                    sh_d    = sh_shift;
                    pairs_d = pairs_q - 3'd1;
                end
            end
            S_MARK: begin
                if (cnt_q == (dash_q ? T_3U : T_1U)) begin
                    sh_d    = sh_shift;
                    pairs_d = pairs_q - 3'd1;
                    state_d = any_sym(sh_shift) ? S_SYM_GAP : S_CHAR_GAP;
                end
            end
            S_SYM_GAP:  if (cnt_q == T_1U) state_d = S_SEEK;
            S_CHAR_GAP: if (cnt_q == T_3U) state_d = S_IDLE;
            S_WORD_GAP: if (cnt_q == T_4U) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (state_d != state_q || state_q == S_IDLE || state_q == S_SEEK) begin
            cnt_d = '0;
        end
        key_out_d = (state_d == S_MARK);
        busy_d    = (state_q != S_IDLE) || (count_q != '0);
    end

    // FIFO bookkeeping; ready is recomputed from the next count so it tracks count_q exactly.
    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ready_d  = (count_d < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            pairs_q   <= '0;
            dash_q    <= 1'b0;
            key_out_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            pairs_q   <= pairs_d;
            dash_q    <= dash_d;
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= code_if.code_in;
        end
    end

    assign key_out            = key_out_q;
    assign busy               = busy_q;
    assign fifo_count         = count_q;
    assign code_if.code_ready = ready_q;

`ifdef MORSE_SIDETONE_EN
    localparam int unsigned TW = $clog2(TONE_DIV + 1);

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          tone_q, tone_d;

    // Sidetone runs only while the mark continues; it drops together with key_out.
    always_comb begin
        tone_cnt_d = '0;
        tone_d     = 1'b0;
        if (state_q == S_MARK && state_d == S_MARK) begin
            if (tone_cnt_q == TW'(TONE_DIV - 1)) begin
                tone_d = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TW'(1);
                tone_d     = tone_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign tone_out = tone_q;
`endif
endmodule

// File: tb/tb_morse_key_scheduler.sv
// Randomized bench for morse_key_scheduler against a timeline model built from the
// unit-timing rules (mark/gap intervals computed per code at its pop edge).
`timescale 1ns/1ps
module tb_morse_key_scheduler;
    localparam int U     = 4;
    localparam int DEPTH = 4;
    localparam int TDIV  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_out;
    logic          busy;
    logic [CW-1:0] fifo_count;
`ifdef MORSE_SIDETONE_EN
    logic          tone_out;
`endif

    always #5 clk = ~clk;

    morse_key_scheduler_if cif ();

    morse_key_scheduler #(
        .UNIT_TIME (U),
        .FIFO_DEPTH(DEPTH),
        .TONE_DIV  (TDIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_if   (cif),
        .key_out   (key_out),
        .busy      (busy),
        .fifo_count(fifo_count)
`ifdef MORSE_SIDETONE_EN
        ,
        .tone_out  (tone_out)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         t = 0;
    int         idle_at = 0;
    bit         busy_nxt = 1'b0;
    int         valid_pct = 0;
    logic [7:0] mq[$];
    logic [7:0] src_q[$];
    int         mk_s[$];
    int         mk_e[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    // Marks of a code popped at edge p: first mark 1+skips after p, U+1 key-low between
    // adjacent symbols plus skipped pairs, 3U char gap; symbol-less codes spend 1+4U.
    task automatic schedule(input logic [7:0] code, input int p);
        int         pos[$];
        logic [1:0] pr;
        int         s, e;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            pr = code[7-2*i -: 2];
            if (pr == 2'b01 || pr == 2'b10) pos.push_back(i);
        end
        if (pos.size() == 0) begin
            idle_at = p + 1 + 4 * U;
            return;
        end
        s = p + 1 + pos[0];
        foreach (pos[k]) begin
            pr = code[7-2*pos[k] -: 2];
            e  = s + ((pr == 2'b10) ? 3 * U : U);
            mk_s.push_back(s);
            mk_e.push_back(e);
            if (k + 1 < pos.size()) s = e + U + (pos[k+1] - pos[k]);
        end
        idle_at = e + 3 * U;
    endtask

    task automatic cycle();
        bit ek;
        int es;
        bit acc;
        @(negedge clk);
        if (src_q.size() != 0 && $urandom_range(99, 0) >= valid_pct) begin
            cif.code_valid = 1'b1;
            cif.code_in    = src_q[0];
        end else begin
            cif.code_valid = 1'b0;
            cif.code_in    = 8'($urandom);
        end
        @(posedge clk);
        t++;
        acc = cif.code_valid && (mq.size() < DEPTH);
        if (mq.size() != 0 && idle_at <= t - 1) schedule(mq.pop_front(), t);
        if (acc) begin
            mq.push_back(cif.code_in);
            void'(src_q.pop_front());
        end
        while (mk_e.size() != 0 && mk_e[0] <= t) begin
            void'(mk_s.pop_front());
            void'(mk_e.pop_front());
        end
        ek = 1'b0;
        es = 0;
        if (mk_s.size() != 0 && mk_s[0] <= t) begin
            ek = 1'b1;
            es = mk_s[0];
        end
        #1;
        check_eq("key_out",    32'(key_out),        32'(ek));
        check_eq("fifo_count", 32'(fifo_count),     32'(mq.size()));
        check_eq("code_ready", 32'(cif.code_ready), 32'(mq.size() < DEPTH));
        check_eq("busy",       32'(busy),           32'(busy_nxt));
`ifdef MORSE_SIDETONE_EN
        check_eq("tone_out",   32'(tone_out),       ek ? 32'(((t - es) / TDIV) % 2) : 32'd0);
`endif
        busy_nxt = (idle_at > t) || (mq.size() != 0);
    endtask

    task automatic model_reset();
        mq.delete();
        src_q.delete();
        mk_s.delete();
        mk_e.delete();
        idle_at  = 0;
        busy_nxt = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((src_q.size() != 0 || mq.size() != 0 || idle_at > t ||
                mk_e.size() != 0 || busy_nxt || busy !== 1'b0) && n < maxc) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", 32'(n >= maxc), 32'd0);
        repeat (3) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_key"},   32'(key_out),        32'd0);
        check_eq({tag, "_count"}, 32'(fifo_count),     32'd0);
        check_eq({tag, "_ready"}, 32'(cif.code_ready), 32'd1);
        check_eq({tag, "_busy"},  32'(busy),           32'd0);
`ifdef MORSE_SIDETONE_EN
        check_eq({tag, "_tone"},  32'(tone_out),       32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n          = 1'b1;
        cif.code_valid = 1'b0;
        cif.code_in    = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        release_reset();

        // Directed: E, R-style mixed code, dot-dot / word / dash, backpressure burst
        src_q = {8'h01};
        run_until_idle(500);
        src_q = {8'h19};
        run_until_idle(500);
        src_q = {8'h05, 8'h00, 8'h02};
        run_until_idle(800);
        src_q = {8'h01, 8'h02, 8'h05, 8'h06, 8'h09, 8'h0A};
        run_until_idle(2000);

        // Random codes, with and without valid gaps
        valid_pct = 30;
        for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
        run_until_idle(6000);
        valid_pct = 0;
        for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
        run_until_idle(3000);

        // Reset in the middle of a dash with codes still queued
        src_q = {8'h02, 8'h01, 8'h19};
        n = 0;
        while (!(mk_s.size() != 0 && mk_s[0] <= t && t - mk_s[0] >= 5) && n < 200) begin
            cycle();
            n++;
        end
        check_eq("dash_reached", 32'(n >= 200), 32'd0);
        #2;
        rst_n          = 1'b0;
        cif.code_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        release_reset();
        src_q = {8'h01};
        run_until_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
